// File: rtl/clk_freq_monitor.sv
// Counts rising edges of an asynchronous monitored clock over a fixed window of system clocks
// and flags out-of-range or lost clocks. Optional sticky error via `CLK_MON_STICKY_ERR_EN.
module clk_freq_monitor #(
  parameter int WINDOW     = 1000,
  parameter int CNT_W      = 16,
  parameter int EXP_MIN    = 245,
  parameter int EXP_MAX    = 255,
  parameter int LOST_LIMIT = 64
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             mon_clk,
`ifdef CLK_MON_STICKY_ERR_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic [CNT_W-1:0] freq_count,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             clk_lost
);

  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int IDLE_W = $clog2(LOST_LIMIT + 1);

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  EXP_MIN_C = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  EXP_MAX_C = CNT_W'(EXP_MAX);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(LOST_LIMIT);

  logic              s1, s2, s3;
  logic              rise;
  logic [0:0]        state;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  captured;
  logic [IDLE_W-1:0] idle_cnt;
  logic              win_end;
  logic              in_range;

  assign rise    = s2 & ~s3;
  assign win_end = (win_cnt == WIN_LAST);

  // An edge landing on the closing cycle belongs to the closing window.
  always_comb begin
    captured = edge_cnt;
    if (rise && (edge_cnt != CNT_MAX)) begin
      captured = edge_cnt + CNT_W'(1);
    end else begin
      captured = edge_cnt;
    end
    in_range = (captured >= EXP_MIN_C) && (captured <= EXP_MAX_C);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else if (win_end) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      edge_cnt <= captured;
    end
  end

  // The warm-up window is discarded: the synchronizer and counters start mid-period.
  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= ST_WARMUP;
      freq_count <= '0;
      freq_ok    <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_WARMUP: begin
          if (win_end) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (win_end) begin
            freq_count <= captured;
            freq_ok    <= in_range;
            meas_valid <= 1'b1;
          end
        end
        default: state <= ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      idle_cnt <= '0;
      clk_lost <= 1'b0;
    end else begin
      if (rise) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LIM) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      clk_lost <= (idle_cnt == IDLE_LIM);
    end
  end

`ifdef CLK_MON_STICKY_ERR_EN
  // A new error outranks a simultaneous clear so no failure is ever lost.
  always_ff @(posedge clk) begin
    if (RST) begin
      err_sticky <= 1'b0;
    end else if ((meas_valid && !freq_ok) || clk_lost) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor; cycle numbering restarts at 0 on the first cycle with RST=0.
// The monitored clock is driven on the falling edge of clk from a per-scenario pattern function.
module tb_clk_freq_monitor;

  logic        clk;
  logic        RST;
  logic        mon_clk;
  logic [15:0] freq_count;
  logic        meas_valid;
  logic        freq_ok;
  logic        clk_lost;
`ifdef CLK_MON_STICKY_ERR_EN
  logic        err_clr;
  logic        err_sticky;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  int scen;
  int n_pulse;
  int first_pulse;
  int lost_seen;

  clk_freq_monitor dut (
    .clk        (clk),
    .RST        (RST),
    .mon_clk    (mon_clk),
`ifdef CLK_MON_STICKY_ERR_EN
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
`endif
    .freq_count (freq_count),
    .meas_valid (meas_valid),
    .freq_ok    (freq_ok),
    .clk_lost   (clk_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic div4(input int c);
    return logic'((c >> 1) & 1);
  endfunction

  function automatic logic tog(input int c);
    return logic'(c & 1);
  endfunction

  function automatic logic mon_val(input int c);
    case (scen)
      0: begin
        if (c <= 4000)      return div4(c);
        else if (c <= 6000) return tog(c);
        else if (c <= 8000) return 1'b0;
        else                return div4(c);
      end
      1: return logic'(((c >= 1002) && (c <= 1994) && ((c % 4) == 2)) || (c == 1997));
      2: return logic'(((c >= 1002) && (c <= 1994) && ((c % 4) == 2)) || (c == 1998));
      4: begin
        if (((c >= 1998) && (c <= 2990)) || ((c >= 4500) && (c <= 4990))) return tog(c);
        else return div4(c);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_stats();
    cyc = 0;
    n_pulse = 0;
    first_pulse = -1;
    lost_seen = 0;
  endtask

  task automatic step();
    mon_clk = mon_val(cyc);
    if (meas_valid) begin
      if (n_pulse == 0) first_pulse = cyc;
      n_pulse++;
    end
    if (clk_lost) lost_seen = 1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    mon_clk = 1'b0;
`ifdef CLK_MON_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    RST = 1'b0;
    clear_stats();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, int'(freq_count), 0);
    check({tag, "_valid"}, int'(meas_valid), 0);
    check({tag, "_ok"},    int'(freq_ok),    0);
    check({tag, "_lost"},  int'(clk_lost),   0);
  endtask

  initial begin
    // 25 MHz, then 50 MHz, then dead, then 25 MHz again
    scen = 0;
    do_reset();
    check_zero("rst0");
    run_to(4001);
    check("p25_first",   first_pulse, 2000);
    check("p25_npulse",  n_pulse, 3);
    check("p25_count",   int'(freq_count), 250);
    check("p25_ok",      int'(freq_ok), 1);
    check("p25_nolost",  lost_seen, 0);
    run_to(6000);
    check("p50_valid",   int'(meas_valid), 1);
    check("p50_count",   int'(freq_count), 500);
    check("p50_ok",      int'(freq_ok), 0);
    run_to(6066);
    check("lost_before", int'(clk_lost), 0);
    step();
    check("lost_set",    int'(clk_lost), 1);
    run_to(7000);
    check("dead_valid1", int'(meas_valid), 1);
    check("dead_count1", int'(freq_count), 1);
    run_to(8000);
    check("dead_count0", int'(freq_count), 0);
    check("dead_ok",     int'(freq_ok), 0);
    run_to(8005);
    check("lost_hold",   int'(clk_lost), 1);
    step();
    check("lost_clr",    int'(clk_lost), 0);
    run_to(9000);
    check("restart_cnt", int'(freq_count), 249);
    check("restart_ok",  int'(freq_ok), 1);
`ifdef CLK_MON_STICKY_ERR_EN
    check("stk_s0",      int'(err_sticky), 1);
`endif
    do_reset();
    check_zero("rst1");

    // rise on the window-end cycle belongs to the closing window
    scen = 1;
    do_reset();
    run_to(2000);
    check("bndA_count",  int'(freq_count), 250);
    check("bndA_ok",     int'(freq_ok), 1);
    run_to(3000);
    check("bndA_next",   int'(freq_count), 0);
    scen = 2;
    do_reset();
    run_to(2000);
    check("bndB_count",  int'(freq_count), 249);
    run_to(3000);
    check("bndB_next",   int'(freq_count), 1);

    // reset mid warm-up window at cycle 1500
    scen = 4;
    do_reset();
    run_to(1500);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mid_nopulse", n_pulse, 0);
    clear_stats();
    check_zero("rst2");
    run_to(2001);
    check("mid_first",   first_pulse, 2000);
    check("mid_count",   int'(freq_count), 250);
    run_to(3001);
    check("mid_fail_ok", int'(freq_ok), 0);
    run_to(4001);
    check("mid_ok_cnt",  int'(freq_count), 250);
    check("mid_ok_ok",   int'(freq_ok), 1);
`ifdef CLK_MON_STICKY_ERR_EN
    check("stk_hold",    int'(err_sticky), 1);
    run_to(4100);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("stk_clr",     int'(err_sticky), 0);
`endif
    run_to(5000);
    check("mid_v5000",   int'(meas_valid), 1);
    check("mid_ok5000",  int'(freq_ok), 0);
`ifdef CLK_MON_STICKY_ERR_EN
    check("stk_pre",     int'(err_sticky), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("stk_setwins", int'(err_sticky), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
